serial_subtractor: RTL and testbench
====================================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter WIDTH, default 4: operand and result width in bits, legal range 2..16.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port start, input, 1: request to begin an operation; sampled only in IDLE.
REQ-005 SHALL have port a, input, WIDTH: minuend; sampled with start.
REQ-006 SHALL have port b, input, WIDTH: subtrahend; sampled with start.
REQ-007 SHALL have port b_in, input, 1: borrow-in; sampled with start.
REQ-008 SHALL have port busy, output, 1: high while an operation is in progress (RUN state).
REQ-009 SHALL have port done, output, 1: one-cycle pulse marking diff/b_out valid.
REQ-010 SHALL have port diff, output, WIDTH: result a - b - b_in, modulo 2^WIDTH.
REQ-011 SHALL have port b_out, output, 1: borrow-out; 1 when a < b + b_in (unsigned).

Function
REQ-012 SHALL implement FSM states IDLE, RUN, DONE; reset state IDLE.
REQ-013 IDLE: start=1 at a rising edge -> latch a, b, b_in into internal shift registers and borrow flop; clear bit counter; go to RUN.
REQ-014 IDLE: start=0 -> remain in IDLE; diff/b_out hold their last values.
REQ-015 RUN: process one bit per cycle, LSB first: d = a_i ^ b_i ^ br; br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br).
REQ-016 RUN: shift d into the result register from the MSB end; shift operand registers right by one; increment the counter.
REQ-017 RUN: after the WIDTH-th bit, go to DONE; diff and b_out update on that same edge.
REQ-018 done SHALL rise on the WIDTH-th rising edge after the edge sampling start, stay high exactly one cycle, then the FSM returns to IDLE.
REQ-019 busy SHALL be 1 exactly in RUN: WIDTH cycles per operation.
REQ-020 start SHALL be ignored in RUN and DONE; no queuing. Minimum start-to-start spacing is WIDTH+2 cycles.
REQ-021 Input changes on a, b and b_in after the sampling edge SHALL NOT affect the operation in progress.
REQ-022 diff and b_out SHALL stay stable from done until the next operation completes; partial results are never visible on diff.
REQ-023 Counter width SHALL be ceil(log2(WIDTH+1)); no wrap-around occurs within an operation.

Reset
REQ-024 rst_n=0 SHALL immediately, regardless of clk, force: state IDLE, busy=0, done=0, diff=0, b_out=0, internal registers and counter to 0.
REQ-025 Reset during RUN or DONE SHALL abort the operation with no done pulse; the first start after rst_n deasserts SHALL be accepted normally.

Configuration
REQ-026 Macro SERIAL_SUB_OVERFLOW_EN defined: the block SHALL add output port ovf, 1 bit, reset 0, updated with diff. ovf = 1 when the signed two's-complement result of a - b - b_in does not fit in WIDTH bits, i.e. the borrow into the MSB differs from b_out.
REQ-027 Macro SERIAL_SUB_OVERFLOW_EN undefined: port ovf and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-028 a=9, b=3, b_in=0, start one cycle -> busy high 4 cycles; done pulse 4 edges after start; diff=6, b_out=0.
REQ-029 a=3, b=9, b_in=0 -> diff=10 (4'b1010), b_out=1; then a=0, b=0, b_in=1 -> diff=15, b_out=1.
REQ-030 a=15, b=15, b_in=0 followed by start pulses held high through RUN/DONE -> exactly one done; diff=0, b_out=0; the next operation starts only from IDLE.
REQ-031 Start a=12, b=5; drop rst_n after 2 RUN cycles -> busy, done, diff and b_out go to 0 asynchronously, with no done pulse; after release, a=12, b=5 -> diff=7, b_out=0.
REQ-032 With SERIAL_SUB_OVERFLOW_EN defined: a=7, b=8, b_in=0 -> diff=15, b_out=1, ovf=1; a=5, b=2 -> ovf=0.
REQ-033 WIDTH=8: a=0x00, b=0x01, b_in=0 -> busy for 8 cycles; diff=0xFF, b_out=1.

Source files
------------

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b - b_in, LSB first, one bit per clock.
// An operation is launched from IDLE by start, runs WIDTH cycles in RUN,
// then presents a one-cycle done pulse in DONE. diff/b_out only change
// at completion, so partial results are never visible.
// Optional feature: define SERIAL_SUB_OVERFLOW_EN to add the signed
// overflow flag output ovf (updated together with diff).
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             b_out
`ifdef SERIAL_SUB_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  // Holds the upper WIDTH-1 result bits collected so far; the final bit
  // is merged in on the completing edge straight into diff.
  logic [WIDTH-2:0] res_sh;
  logic             br;
  logic [CNT_W-1:0] cnt;

  logic             d_bit;
  logic             br_next;
  logic             last_bit;
  logic [WIDTH-1:0] res_next;

  // Full-subtractor cell for the current bit and the shifted result word.
  always_comb begin
    d_bit    = a_sh[0] ^ b_sh[0] ^ br;
    br_next  = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
    res_next = {d_bit, res_sh};
    last_bit = (cnt == CNT_W'(WIDTH - 1));
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic and status outputs decoded from the state.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: if (start) state_next = RUN;
      RUN: begin
        busy = 1'b1;
        if (last_bit) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand capture, serial shifting and result publication.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      br     <= 1'b0;
      cnt    <= '0;
      diff   <= '0;
      b_out  <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
      ovf    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh   <= a;
            b_sh   <= b;
            br     <= b_in;
            res_sh <= '0;
            cnt    <= '0;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          br     <= br_next;
          res_sh <= res_next[WIDTH-1:1];
          cnt    <= cnt + CNT_W'(1);
          if (last_bit) begin
            diff  <= res_next;
            b_out <= br_next;
`ifdef SERIAL_SUB_OVERFLOW_EN
            // Borrow into the MSB differing from borrow out of it means
            // the signed result does not fit in WIDTH bits.
            ovf   <= br ^ br_next;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: a WIDTH=4 and a WIDTH=8 instance.
// Stimulus tasks push hand-computed expected results; per-instance monitors
// pop and compare on every done pulse.
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic       start4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       bin4 = 1'b0;
  logic       busy4, done4, bout4;
  logic [3:0] diff4;

  logic       start8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       bin8 = 1'b0;
  logic       busy8, done8, bout8;
  logic [7:0] diff8;

`ifdef SERIAL_SUB_OVERFLOW_EN
  logic ovf4, ovf8;
`endif

  int errors = 0;
  int checks = 0;

  logic [5:0] q4[$];
  logic [9:0] q8[$];
  logic [5:0] e4;
  logic [9:0] e8;
  int         busy_cnt4 = 0, busy_cnt8 = 0;
  logic [3:0] last4 = '0;
  logic [7:0] last8 = '0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(4)) u4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .b_in(bin4),
    .busy(busy4), .done(done4), .diff(diff4), .b_out(bout4)
`ifdef SERIAL_SUB_OVERFLOW_EN
    , .ovf(ovf4)
`endif
  );

  serial_subtractor #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .b_in(bin8),
    .busy(busy8), .done(done8), .diff(diff8), .b_out(bout8)
`ifdef SERIAL_SUB_OVERFLOW_EN
    , .ovf(ovf8)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor for the 4-bit instance.
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_cnt4 = 0;
      last4     = '0;
    end else if (done4) begin
      if (q4.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done4: diff %0h with empty scoreboard", diff4);
      end else begin
        e4 = q4.pop_front();
        check("diff4", diff4, e4[3:0]);
        check("bout4", bout4, e4[4]);
`ifdef SERIAL_SUB_OVERFLOW_EN
        check("ovf4", ovf4, e4[5]);
`endif
        check("busy_cycles4", busy_cnt4, 4);
      end
      busy_cnt4 = 0;
      last4     = diff4;
    end else begin
      if (busy4) busy_cnt4++;
      check("diff_hold4", diff4, last4);
    end
  end

  // Monitor for the 8-bit instance.
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_cnt8 = 0;
      last8     = '0;
    end else if (done8) begin
      if (q8.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done8: diff %0h with empty scoreboard", diff8);
      end else begin
        e8 = q8.pop_front();
        check("diff8", diff8, e8[7:0]);
        check("bout8", bout8, e8[8]);
`ifdef SERIAL_SUB_OVERFLOW_EN
        check("ovf8", ovf8, e8[9]);
`endif
        check("busy_cycles8", busy_cnt8, 8);
      end
      busy_cnt8 = 0;
      last8     = diff8;
    end else begin
      if (busy8) busy_cnt8++;
      check("diff_hold8", diff8, last8);
    end
  end

  // One 4-bit operation; operands are scrambled right after sampling.
  task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic bin,
                     input logic [3:0] ed, input logic eb, input logic eo);
    int n;
    @(negedge clk);
    a4 = a; b4 = b; bin4 = bin; start4 = 1'b1;
    q4.push_back({eo, eb, ed});
    @(posedge clk); #1;
    start4 = 1'b0; a4 = ~a; b4 = ~b; bin4 = ~bin;
    n = 0;
    while (n < 40) begin
      @(posedge clk); #1; n++;
      if (done4) break;
    end
    check("latency4", n, 4);
    @(posedge clk);
  endtask

  // One 8-bit operation.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic bin,
                     input logic [7:0] ed, input logic eb, input logic eo);
    int n;
    @(negedge clk);
    a8 = a; b8 = b; bin8 = bin; start8 = 1'b1;
    q8.push_back({eo, eb, ed});
    @(posedge clk); #1;
    start8 = 1'b0; a8 = ~a; b8 = ~b; bin8 = ~bin;
    n = 0;
    while (n < 60) begin
      @(posedge clk); #1; n++;
      if (done8) break;
    end
    check("latency8", n, 8);
    @(posedge clk);
  endtask

  initial begin : stim
    int n;
    // Reset state, before any clock edge.
    #1;
    check("rst_busy", busy4, 0);
    check("rst_done", done4, 0);
    check("rst_diff", diff4, 0);
    check("rst_bout", bout4, 0);
`ifdef SERIAL_SUB_OVERFLOW_EN
    check("rst_ovf", ovf4, 0);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    op4(4'd9, 4'd3, 1'b0, 4'd6,  1'b0, 1'b1);
    op4(4'd3, 4'd9, 1'b0, 4'd10, 1'b1, 1'b1);
    op4(4'd0, 4'd0, 1'b1, 4'd15, 1'b1, 1'b0);
    op4(4'd6, 4'd2, 1'b1, 4'd3,  1'b0, 1'b0);
    op4(4'd2, 4'd2, 1'b1, 4'd15, 1'b1, 1'b0);
    op4(4'd7, 4'd8, 1'b0, 4'd15, 1'b1, 1'b1);
    op4(4'd5, 4'd2, 1'b0, 4'd3,  1'b0, 1'b0);

    // start held high through RUN and DONE: exactly one result.
    @(negedge clk);
    a4 = 4'd15; b4 = 4'd15; bin4 = 1'b0; start4 = 1'b1;
    q4.push_back({1'b0, 1'b0, 4'd0});
    @(posedge clk); #1;
    n = 0;
    while (n < 40) begin
      @(posedge clk); #1; n++;
      if (done4) break;
    end
    check("latency_held4", n, 4);
    @(negedge clk);
    start4 = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      check("no_restart4", busy4, 0);
    end

    op8(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
    op8(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
    op8(8'h5A, 8'h3C, 1'b1, 8'h1D, 1'b0, 1'b0);

    // Abort a 12-5 operation two RUN cycles in with an asynchronous reset.
    op4(4'd3, 4'd9, 1'b0, 4'd10, 1'b1, 1'b1);
    @(negedge clk);
    a4 = 4'd12; b4 = 4'd5; bin4 = 1'b0; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy4, 0);
    check("abort_done", done4, 0);
    check("abort_diff", diff4, 0);
    check("abort_bout", bout4, 0);
    check("abort_diff8", diff8, 0);
    repeat (2) begin
      @(posedge clk); #1;
      check("abort_no_done", done4, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    op4(4'd12, 4'd5, 1'b0, 4'd7, 1'b0, 1'b1);

    repeat (4) @(posedge clk);
    check("q4_drained", q4.size(), 0);
    check("q8_drained", q8.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
